// File: rtl/regfile_mp_if.sv
// Register-file bus bundle: write ports, read ports and scoreboard control.
// The master side belongs to issue/writeback logic; the slave side is the register file.
`timescale 1ns/1ps
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int NRD    = 2,
  parameter int NWR    = 1
);
  localparam int AW = $clog2(NREGS);

  logic [NWR-1:0]        we;
  logic [NWR*AW-1:0]     waddr;
  logic [NWR*DATA_W-1:0] wdata;
  logic [NRD*AW-1:0]     raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rbusy;
  logic                  alloc_valid;
  logic [AW-1:0]         alloc_addr;
  logic                  flush;
  logic [NREGS-1:0]      busy_vec;

  modport master (
    output we, waddr, wdata, raddr, alloc_valid, alloc_addr, flush,
    input  rdata, rbusy, busy_vec
  );

  modport slave (
    input  we, waddr, wdata, raddr, alloc_valid, alloc_addr, flush,
    output rdata, rbusy, busy_vec
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional write-to-read bypass
// and a per-register busy scoreboard; register 0 is hardwired to zero.
`timescale 1ns/1ps
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;

  // NOTE: the storage array is reset because every register must read 0 while
  // rst is high; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments; with several ports on one address the
      // last (highest-index) assignment in the loop is the one that lands.
      for (int k = 0; k < NWR; k++) begin
        if (bus.we[k] && bus.waddr[k*AW +: AW] != '0)
          regs[bus.waddr[k*AW +: AW]] <= bus.wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // Priority, lowest applied first so later lines override: writeback clear,
  // then allocation set (newer producer), then flush.
  always_comb begin
    // NOTE: default first so every path assigns busy_nxt and no latch is inferred.
    busy_nxt = busy;
    for (int i = 0; i < NREGS; i++) begin
      for (int k = 0; k < NWR; k++) begin
        if (bus.we[k] && bus.waddr[k*AW +: AW] == AW'(i)) busy_nxt[i] = 1'b0;
      end
    end
    if (bus.alloc_valid && bus.alloc_addr != '0) busy_nxt[bus.alloc_addr] = 1'b1;
    if (bus.flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign bus.busy_vec = busy;

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] rd;

    assign ra = bus.raddr[j*AW +: AW];

    always_comb begin
      rd = regs[ra];
      if (BYPASS != 0) begin
        for (int k = 0; k < NWR; k++) begin
          if (bus.we[k] && bus.waddr[k*AW +: AW] == ra) rd = bus.wdata[k*DATA_W +: DATA_W];
        end
      end
      // Reset also masks the bypass path so rdata is 0 for the whole reset window.
      if (ra == '0 || rst) rd = '0;
    end

    assign bus.rdata[j*DATA_W +: DATA_W] = rd;
    assign bus.rbusy[j] = busy[ra];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing and a non-bypassing instance
// (both two write ports, two read ports) driven with identical stimulus.
`timescale 1ns/1ps
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int NR = 16;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  regfile_mp_if #(.DATA_W(DW), .NREGS(NR), .NRD(2), .NWR(2)) bus1 ();
  regfile_mp_if #(.DATA_W(DW), .NREGS(NR), .NRD(2), .NWR(2)) bus0 ();

  regfile_mp #(.DATA_W(DW), .NREGS(NR), .NRD(2), .NWR(2), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  regfile_mp #(.DATA_W(DW), .NREGS(NR), .NRD(2), .NWR(2), .BYPASS(0)) dut_nobyp (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  assign bus0.we          = bus1.we;
  assign bus0.waddr       = bus1.waddr;
  assign bus0.wdata       = bus1.wdata;
  assign bus0.raddr       = bus1.raddr;
  assign bus0.alloc_valid = bus1.alloc_valid;
  assign bus0.alloc_addr  = bus1.alloc_addr;
  assign bus0.flush       = bus1.flush;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [1:0] we_v, input logic [3:0] wa1, input logic [3:0] wa0,
                       input logic [31:0] wd1, input logic [31:0] wd0,
                       input logic [3:0] ra1, input logic [3:0] ra0,
                       input logic av, input logic [3:0] aa, input logic fl);
    bus1.we          = we_v;
    bus1.waddr       = {wa1, wa0};
    bus1.wdata       = {wd1, wd0};
    bus1.raddr       = {ra1, ra0};
    bus1.alloc_valid = av;
    bus1.alloc_addr  = aa;
    bus1.flush       = fl;
  endtask

  task automatic idle(input logic [3:0] ra1, input logic [3:0] ra0);
    drive(2'b00, 4'd0, 4'd0, 32'd0, 32'd0, ra1, ra0, 1'b0, 4'd0, 1'b0);
  endtask

  // Reset pulse inside one low phase; a bypassable write is pending to show reset masks it.
  task automatic test_reset();
    @(negedge clk);
    drive(2'b01, 4'd0, 4'd5, 32'd0, 32'h5555_5555, 4'd1, 4'd0, 1'b1, 4'd3, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus1.raddr = {4'(2*i+1), 4'(2*i)};
      if (i == 2) bus1.raddr = {4'd5, 4'd5};
      #0.5;
      total++;
      if (bus1.rdata !== 64'd0 || bus0.rdata !== 64'd0 || bus1.rbusy !== 2'b00 || bus1.busy_vec !== 16'd0)
        $display("FAIL reset_read[%0d]: rdata=%h/%h rbusy=%b busy_vec=%h, expected all 0",
                 i, bus1.rdata, bus0.rdata, bus1.rbusy, bus1.busy_vec);
      else passed++;
    end
    idle(4'd0, 4'd0);
    rst = 1'b0;
  endtask

  task automatic test_write_bypass();
    @(negedge clk);
    drive(2'b01, 4'd0, 4'd5, 32'd0, 32'hDEAD_BEEF, 4'd0, 4'd5, 1'b0, 4'd0, 1'b0);
    #1;
    total++;
    if (bus1.rdata[31:0] !== 32'hDEAD_BEEF)
      $display("FAIL bypass_same_cycle: got %h, expected deadbeef", bus1.rdata[31:0]);
    else passed++;
    total++;
    if (bus0.rdata[31:0] !== 32'h0)
      $display("FAIL nobypass_same_cycle: got %h, expected 00000000", bus0.rdata[31:0]);
    else passed++;
    @(negedge clk);
    idle(4'd0, 4'd5);
    #1;
    total++;
    if (bus0.rdata[31:0] !== 32'hDEAD_BEEF || bus1.rdata[31:0] !== 32'hDEAD_BEEF)
      $display("FAIL write_next_cycle: got %h/%h, expected deadbeef", bus1.rdata[31:0], bus0.rdata[31:0]);
    else passed++;
  endtask

  task automatic test_port_conflict_and_r0();
    @(negedge clk);
    drive(2'b11, 4'd3, 4'd3, 32'h22, 32'h11, 4'd0, 4'd3, 1'b0, 4'd0, 1'b0);
    #1;
    total++;
    if (bus1.rdata[31:0] !== 32'h22)
      $display("FAIL bypass_conflict: got %h, expected 00000022", bus1.rdata[31:0]);
    else passed++;
    @(negedge clk);
    drive(2'b01, 4'd0, 4'd0, 32'd0, 32'hFF, 4'd3, 4'd0, 1'b0, 4'd0, 1'b0);
    #1;
    total++;
    if (bus0.rdata[63:32] !== 32'h22 || bus1.rdata[63:32] !== 32'h22)
      $display("FAIL write_conflict: got %h/%h, expected 00000022", bus1.rdata[63:32], bus0.rdata[63:32]);
    else passed++;
    total++;
    if (bus1.rdata[31:0] !== 32'h0 || bus1.rbusy[0] !== 1'b0)
      $display("FAIL r0_bypass: got %h busy %b, expected 00000000 busy 0", bus1.rdata[31:0], bus1.rbusy[0]);
    else passed++;
    @(negedge clk);
    idle(4'd3, 4'd0);
    #1;
    total++;
    if (bus0.rdata[31:0] !== 32'h0 || bus1.rdata[31:0] !== 32'h0)
      $display("FAIL r0_stored: got %h/%h, expected 00000000", bus1.rdata[31:0], bus0.rdata[31:0]);
    else passed++;
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    drive(2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 4'd7, 4'd0, 1'b1, 4'd7, 1'b0);
    #1;
    total++;
    if (bus1.rbusy[1] !== 1'b0 || bus1.busy_vec !== 16'h0000)
      $display("FAIL alloc_same_cycle: rbusy %b busy_vec %h, expected 0 and 0000", bus1.rbusy[1], bus1.busy_vec);
    else passed++;
    @(negedge clk);
    drive(2'b01, 4'd0, 4'd7, 32'd0, 32'h77, 4'd7, 4'd0, 1'b0, 4'd0, 1'b0);
    #1;
    total++;
    if (bus1.rbusy[1] !== 1'b1 || bus1.busy_vec !== 16'h0080)
      $display("FAIL alloc_next_cycle: rbusy %b busy_vec %h, expected 1 and 0080", bus1.rbusy[1], bus1.busy_vec);
    else passed++;
    @(negedge clk);
    drive(2'b10, 4'd7, 4'd0, 32'h99, 32'd0, 4'd7, 4'd0, 1'b1, 4'd7, 1'b0);
    #1;
    total++;
    if (bus1.rbusy[1] !== 1'b0 || bus1.busy_vec !== 16'h0000 || bus0.rdata[63:32] !== 32'h77)
      $display("FAIL writeback_clear: rbusy %b busy_vec %h data %h, expected 0, 0000, 00000077",
               bus1.rbusy[1], bus1.busy_vec, bus0.rdata[63:32]);
    else passed++;
    @(negedge clk);
    idle(4'd7, 4'd0);
    #1;
    total++;
    if (bus1.busy_vec !== 16'h0080 || bus1.rbusy[1] !== 1'b1 || bus0.rdata[63:32] !== 32'h99)
      $display("FAIL alloc_beats_write: busy_vec %h rbusy %b data %h, expected 0080, 1, 00000099",
               bus1.busy_vec, bus1.rbusy[1], bus0.rdata[63:32]);
    else passed++;
  endtask

  task automatic test_flush();
    @(negedge clk);
    drive(2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b1, 4'd2, 1'b0);
    @(negedge clk);
    bus1.alloc_addr = 4'd4;
    @(negedge clk);
    bus1.alloc_addr = 4'd9;
    @(negedge clk);
    drive(2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b1, 4'd6, 1'b1);
    #1;
    total++;
    if (bus1.busy_vec !== 16'h0294)
      $display("FAIL busy_multi: got %h, expected 0294", bus1.busy_vec);
    else passed++;
    @(negedge clk);
    idle(4'd3, 4'd5);
    #1;
    total++;
    if (bus1.busy_vec !== 16'h0000 || bus0.busy_vec !== 16'h0000)
      $display("FAIL flush_clear: got %h/%h, expected 0000", bus1.busy_vec, bus0.busy_vec);
    else passed++;
    total++;
    if (bus0.rdata !== {32'h22, 32'hDEAD_BEEF})
      $display("FAIL flush_data_kept: got %h, expected 00000022deadbeef", bus0.rdata);
    else passed++;
    bus1.raddr = {4'd7, 4'd6};
    #1;
    total++;
    if (bus0.rdata !== {32'h99, 32'h0})
      $display("FAIL flush_data_kept2: got %h, expected 0000009900000000", bus0.rdata);
    else passed++;
  endtask

  task automatic test_async_reset_mid_op();
    @(negedge clk);
    drive(2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b1, 4'd10, 1'b0);
    @(negedge clk);
    drive(2'b01, 4'd0, 4'd1, 32'd0, 32'h1234, 4'd1, 4'd5, 1'b1, 4'd11, 1'b0);
    #1;
    total++;
    if (bus1.busy_vec !== 16'h0400)
      $display("FAIL busy_before_reset: got %h, expected 0400", bus1.busy_vec);
    else passed++;
    #1 rst = 1'b1;
    #1;
    total++;
    if (bus1.rdata !== 64'd0 || bus0.rdata !== 64'd0 || bus1.rbusy !== 2'b00 ||
        bus1.busy_vec !== 16'd0 || bus0.busy_vec !== 16'd0)
      $display("FAIL reset_immediate: rdata %h/%h rbusy %b busy_vec %h, expected all 0",
               bus1.rdata, bus0.rdata, bus1.rbusy, bus1.busy_vec);
    else passed++;
    idle(4'd1, 4'd5);
    #1 rst = 1'b0;
    @(negedge clk);
    drive(2'b01, 4'd0, 4'd1, 32'd0, 32'hA5, 4'd1, 4'd5, 1'b0, 4'd0, 1'b0);
    #1;
    total++;
    if (bus0.rdata !== 64'd0 || bus1.busy_vec !== 16'd0)
      $display("FAIL reset_cleared_state: rdata %h busy_vec %h, expected 0 and 0000", bus0.rdata, bus1.busy_vec);
    else passed++;
    @(negedge clk);
    idle(4'd1, 4'd5);
    #1;
    total++;
    if (bus0.rdata[63:32] !== 32'hA5 || bus1.rdata[63:32] !== 32'hA5)
      $display("FAIL post_reset_write: got %h/%h, expected 000000a5", bus1.rdata[63:32], bus0.rdata[63:32]);
    else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b0;
    idle(4'd0, 4'd0);
    test_reset();
    test_write_bypass();
    test_port_conflict_and_r0();
    test_scoreboard();
    test_flush();
    test_async_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
